// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: operand-issue and writeback controller around a combinational 16-function ALU
module alu_issue_ctrl #(
    parameter int N     = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [3:0]       ins_func,
    input  logic [3:0]       ins_rs,
    input  logic [3:0]       ins_rt,
    input  logic [3:0]       ins_rd,
    input  logic             ins_use_imm,
    input  logic [IMM_W-1:0] ins_imm,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_cmd,
    input  logic [N-1:0]     alu_z,
    output logic             wb_valid,
    output logic [3:0]       wb_rd,
    output logic [N-1:0]     wb_data,
    output logic [31:0]      retired,
    input  logic [3:0]       dbg_addr,
    output logic [N-1:0]     dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   rf [16];
    logic [3:0]     rd_q;
    logic           unary;
    logic [N-1:0]   rf_a, rf_b, a_nx, b_nx;

    // next-state and handshake: one instruction in flight, ready only when idle
    always_comb begin
        state_nx  = state;
        ins_ready = 1'b0;
        case (state)
            IDLE: begin
                ins_ready = 1'b1;
                state_nx  = ins_valid ? EXEC : IDLE;
            end
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // operand selection; R0 is hardwired to zero on every read port
    always_comb begin
        unary    = ins_func inside {4'd6, 4'd10, 4'd11, 4'd14, 4'd15};
        rf_a     = ins_rs == 4'd0 ? '0 : rf[ins_rs];
        rf_b     = ins_rt == 4'd0 ? '0 : rf[ins_rt];
        a_nx     = ins_func == 4'd14 ? {{(N-IMM_W){1'b0}}, ins_imm} : rf_a;
        b_nx     = unary ? '0 : ins_use_imm ? {{(N-IMM_W){ins_imm[IMM_W-1]}}, ins_imm} : rf_b;
        dbg_data = dbg_addr == 4'd0 ? '0 : rf[dbg_addr];
    end

    // state, operand latch at accept, writeback at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_cmd  <= '0;
            rd_q     <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            retired  <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            state    <= state_nx;
            wb_valid <= state == EXEC;
            if (state == IDLE && ins_valid) begin
                alu_a   <= a_nx;
                alu_b   <= b_nx;
                alu_cmd <= ins_func;
                rd_q    <= ins_rd;
            end
            if (state == EXEC) begin
                if (rd_q != 4'd0) rf[rd_q] <= alu_z;
                wb_data <= alu_z;
                wb_rd   <= rd_q;
                retired <= retired + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench with a behavioural ALU closing the loop on alu_z
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [3:0]  ins_func = '0, ins_rs = '0, ins_rt = '0, ins_rd = '0;
    logic        ins_use_imm = 1'b0;
    logic [15:0] ins_imm = '0;
    logic [31:0] alu_a, alu_b, alu_z;
    logic [3:0]  alu_cmd;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data, retired;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    typedef struct packed {logic [3:0] rd; logic [31:0] data;} exp_t;
    exp_t        sb[$];
    logic [31:0] mrf [16];
    int          vectors = 0, fails = 0, wb_cnt = 0;
    time         t_prev = 0, t_last = 0;
    logic        prev_wb = 1'b0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_func(ins_func), .ins_rs(ins_rs), .ins_rt(ins_rt), .ins_rd(ins_rd),
        .ins_use_imm(ins_use_imm), .ins_imm(ins_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_z(alu_z),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .retired(retired),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ~a;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return $signed(a) >>> b[4:0];
            4'd10: return a + 32'd1;
            4'd11: return a - 32'd1;
            4'd12: return {31'd0, $signed(a) < $signed(b)};
            4'd13: return {31'd0, $signed(a) > $signed(b)};
            4'd14: return a << 16;
            default: return 32'($countones(a));
        endcase
    endfunction

    // behavioural ALU feeding the controller
    always_comb alu_z = alu_f(alu_cmd, alu_a, alu_b);

    // writeback monitor: pops the scoreboard on every retire
    always @(negedge clk) begin
        if (wb_valid) begin
            exp_t e;
            wb_cnt++;
            t_prev = t_last;
            t_last = $time;
            vectors++;
            if (prev_wb) begin
                fails++;
                $display("FAIL wb_pulse_width: wb_valid high two cycles running at %0t, required single-cycle pulse", $time);
            end
            vectors++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: wb_rd=%0d wb_data=%h, required no retire", wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    fails++;
                    $display("FAIL wb_result: got rd=%0d data=%h, required rd=%0d data=%h", wb_rd, wb_data, e.rd, e.data);
                end
                if (e.rd != 4'd0) mrf[e.rd] = e.data;
            end
        end
        prev_wb = wb_valid;
    end

    task automatic issue(input logic [3:0] f, rs, rt, rd, input logic ui, input logic [15:0] imm, input logic hold);
        logic [31:0] a, b;
        int n = 0;
        @(negedge clk);
        while (!ins_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!ins_ready) begin
            fails++;
            $display("FAIL issue_timeout: ins_ready=%b after %0d cycles, required 1", ins_ready, n);
        end
        a = f == 4'd14 ? {16'd0, imm} : (rs == 0 ? 32'd0 : mrf[rs]);
        b = (f inside {4'd6, 4'd10, 4'd11, 4'd14, 4'd15}) ? 32'd0 : ui ? {{16{imm[15]}}, imm} : (rt == 0 ? 32'd0 : mrf[rt]);
        sb.push_back('{rd: rd, data: alu_f(f, a, b)});
        ins_func = f; ins_rs = rs; ins_rt = rt; ins_rd = rd; ins_use_imm = ui; ins_imm = imm;
        ins_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) ins_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !ins_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic rd_rf(input logic [3:0] addr, output logic [31:0] v);
        dbg_addr = addr;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ins_ready !== 1'b1 || wb_valid !== 1'b0 || retired !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: ready=%b wb_valid=%b retired=%h, required 1 0 00000000", ins_ready, wb_valid, retired);
        end
        for (int i = 0; i < 16; i++) begin
            rd_rf(4'(i), v);
            vectors++;
            if (v !== 32'd0) begin
                fails++;
                $display("FAIL reset_rf%0d: got %h, required 00000000", i, v);
            end
        end
    endtask

    task automatic test_add_imm();
        logic [31:0] v1, v2;
        issue(4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 16'h0005, 1'b0);
        issue(4'd0, 4'd0, 4'd0, 4'd2, 1'b1, 16'hFFFD, 1'b0);
        drain();
        rd_rf(4'd1, v1);
        rd_rf(4'd2, v2);
        vectors++;
        if (v1 !== 32'h5 || v2 !== 32'hFFFFFFFD) begin
            fails++;
            $display("FAIL add_imm_rf: rf1=%h rf2=%h, required 00000005 fffffffd", v1, v2);
        end
        vectors++;
        if (t_last - t_prev != 30) begin
            fails++;
            $display("FAIL add_imm_cadence: pulse gap %0t, required 30", t_last - t_prev);
        end
        vectors++;
        if (retired !== 32'd2) begin
            fails++;
            $display("FAIL add_imm_retired: got %0d, required 2", retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v3, v4;
        issue(4'd1, 4'd1, 4'd2, 4'd3, 1'b0, 16'h0, 1'b1);
        issue(4'd0, 4'd3, 4'd3, 4'd4, 1'b0, 16'h0, 1'b0);
        drain();
        rd_rf(4'd3, v3);
        rd_rf(4'd4, v4);
        vectors++;
        if (v3 !== 32'h8 || v4 !== 32'h10) begin
            fails++;
            $display("FAIL back_to_back_rf: rf3=%h rf4=%h, required 00000008 00000010", v3, v4);
        end
        vectors++;
        if (t_last - t_prev != 30) begin
            fails++;
            $display("FAIL back_to_back_cadence: pulse gap %0t, required 30", t_last - t_prev);
        end
    endtask

    task automatic test_unary();
        logic [31:0] v;
        issue(4'd14, 4'd0, 4'd0, 4'd5, 1'b1, 16'h1234, 1'b0);
        vectors++;
        if (alu_a !== 32'h1234 || alu_b !== 32'd0 || alu_cmd !== 4'd14) begin
            fails++;
            $display("FAIL lui_operands: a=%h b=%h cmd=%0d, required 00001234 00000000 14", alu_a, alu_b, alu_cmd);
        end
        drain();
        rd_rf(4'd5, v);
        vectors++;
        if (v !== 32'h12340000) begin
            fails++;
            $display("FAIL lui_rf5: got %h, required 12340000", v);
        end
        issue(4'd10, 4'd1, 4'd0, 4'd0, 1'b1, 16'h7777, 1'b0);
        vectors++;
        if (alu_b !== 32'd0) begin
            fails++;
            $display("FAIL inc_operand_b: got %h, required 00000000", alu_b);
        end
        drain();
        rd_rf(4'd0, v);
        vectors++;
        if (wb_data !== 32'h6 || wb_rd !== 4'd0 || v !== 32'd0) begin
            fails++;
            $display("FAIL inc_rd0: wb_data=%h wb_rd=%0d rf0=%h, required 00000006 0 00000000", wb_data, wb_rd, v);
        end
    endtask

    task automatic test_compare();
        logic [31:0] v6, v7;
        issue(4'd12, 4'd2, 4'd1, 4'd6, 1'b0, 16'h0, 1'b0);
        issue(4'd13, 4'd2, 4'd1, 4'd7, 1'b0, 16'h0, 1'b0);
        drain();
        rd_rf(4'd6, v6);
        rd_rf(4'd7, v7);
        vectors++;
        if (v6 !== 32'd1 || v7 !== 32'd0) begin
            fails++;
            $display("FAIL compare_rf: rf6=%h rf7=%h, required 00000001 00000000", v6, v7);
        end
        vectors++;
        if (retired !== 32'd8) begin
            fails++;
            $display("FAIL compare_retired: got %0d, required 8", retired);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int c0;
        issue(4'd0, 4'd1, 4'd1, 4'd8, 1'b0, 16'h0, 1'b0);
        c0 = wb_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        repeat (5) @(negedge clk);
        vectors++;
        if (wb_cnt != c0) begin
            fails++;
            $display("FAIL reset_mid_wb: %0d pulses after reset, required 0", wb_cnt - c0);
        end
        vectors++;
        if (retired !== 32'd0 || ins_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_state: retired=%h ready=%b, required 00000000 1", retired, ins_ready);
        end
        for (int i = 0; i < 16; i++) begin
            rd_rf(4'(i), v);
            vectors++;
            if (v !== 32'd0) begin
                fails++;
                $display("FAIL reset_mid_rf%0d: got %h, required 00000000", i, v);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        @(negedge clk);
        force dut.retired = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.retired;
        #1;
        vectors++;
        if (retired !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL wrap_preset: got %h, required ffffffff", retired);
        end
        issue(4'd0, 4'd0, 4'd0, 4'd9, 1'b1, 16'h0007, 1'b0);
        drain();
        rd_rf(4'd9, v);
        vectors++;
        if (retired !== 32'd0 || v !== 32'h7) begin
            fails++;
            $display("FAIL wrap_retired: retired=%h rf9=%h, required 00000000 00000007", retired, v);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        test_reset();
        test_add_imm();
        test_back_to_back();
        test_unary();
        test_compare();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
